// File: rtl/pct_trig_pkg.sv
// Shared definitions for the serial trigger receiver: frame length, tag width,
// one-hot receiver states and the frame parity function.
package pct_trig_pkg;

  localparam int TAG_W     = 2;
  localparam int FRAME_LEN = 4;

  // One bit per frame position: start, tag[1], tag[0], parity.
  typedef enum logic [FRAME_LEN-1:0] {
    ST_IDLE = 4'b0001,
    ST_T1   = 4'b0010,
    ST_T0   = 4'b0100,
    ST_PR   = 4'b1000
  } rx_state_e;

  function automatic logic pct_parity(input logic a, input logic b);
    return ~(a ^ b);
  endfunction

endpackage

// File: rtl/pct_tag_fifo.sv
// In-order queue of occupied buffer tags; push and pop may coincide.
// The caller never pushes when full nor pops when empty.
module pct_tag_fifo
  import pct_trig_pkg::*;
#(
  parameter int NBUF = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [TAG_W-1:0] din_i,
  output logic [2:0]       count_o,
  output logic [TAG_W-1:0] head_o
);

  localparam int PTR_W = (NBUF > 1) ? $clog2(NBUF) : 1;

  logic [TAG_W-1:0] mem_q [NBUF];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [2:0]       count_q, count_d;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(NBUF - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    wr_ptr_d = push_i ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = pop_i  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    count_d  = count_q + 3'(push_i) - 3'(pop_i);
  end

  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[wr_ptr_q] <= din_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign count_o = count_q;
  assign head_o  = (count_q != 3'd0) ? mem_q[rd_ptr_q] : '0;

endmodule

// File: rtl/pct_trig_rx.sv
// Serial trigger receiver: decodes 4-bit trigger frames, tracks buffer occupancy
// and drives BufClr. Define PCT_TRIG_RX_STATS_EN for saturating event counters.
module pct_trig_rx
  import pct_trig_pkg::*;
#(
  parameter int NBUF      = 4,
  parameter int BUF_GUARD = 1
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             TrigIn,
  input  logic             BufRelease,
  input  logic [TAG_W-1:0] RelTag,
  output logic             Trig,
  output logic [TAG_W-1:0] TrigTag,
  output logic             BufClr,
  output logic [2:0]       Occ,
  output logic [TAG_W-1:0] HeadTag,
  output logic             HeadValid,
  output logic             ParErr,
  output logic             TagErr,
  output logic             OvfErr,
  output logic             RelErr
`ifdef PCT_TRIG_RX_STATS_EN
  ,
  output logic [15:0]      NTrig,
  output logic [15:0]      NPar,
  output logic [15:0]      NOvf,
  output logic [15:0]      NTagErr
`endif
);

  rx_state_e        state_q;
  logic [TAG_W-1:0] tag_q;
  logic [TAG_W-1:0] exp_tag_q;
  logic [TAG_W-1:0] trig_tag_q;
  logic             trig_q, par_err_q, tag_err_q, ovf_err_q, rel_err_q, buf_clr_q;

  logic [2:0]       occ;
  logic [TAG_W-1:0] head;
  logic             frame_end, par_ok, full;
  logic             accept, ovf, par_bad, tag_bad;
  logic             rel_pop, rel_bad;
  logic [2:0]       occ_d;

  always_comb begin
    frame_end = (state_q == ST_PR);
    par_ok    = (TrigIn == pct_parity(tag_q[1], tag_q[0]));
    full      = (occ == 3'(NBUF));
    accept    = frame_end && par_ok && !full;
    ovf       = frame_end && par_ok && full;
    par_bad   = frame_end && !par_ok;
    tag_bad   = accept && (tag_q != exp_tag_q);
    rel_pop   = BufRelease && (occ != 3'd0);
    // A release on an empty queue is flagged but otherwise ignored.
    rel_bad   = BufRelease && ((occ == 3'd0) || (RelTag != head));
    occ_d     = occ + 3'(accept) - 3'(rel_pop);
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q    <= ST_IDLE;
      tag_q      <= '0;
      exp_tag_q  <= '0;
      trig_tag_q <= '0;
      trig_q     <= 1'b0;
      par_err_q  <= 1'b0;
      tag_err_q  <= 1'b0;
      ovf_err_q  <= 1'b0;
      rel_err_q  <= 1'b0;
      buf_clr_q  <= 1'b1;
    end else begin
      trig_q    <= accept;
      par_err_q <= par_bad;
      tag_err_q <= tag_bad;
      ovf_err_q <= ovf;
      rel_err_q <= rel_bad;
      buf_clr_q <= (int'(occ_d) + BUF_GUARD) < NBUF;
      case (state_q)
        ST_IDLE: if (TrigIn) state_q <= ST_T1;
        ST_T1: begin
          tag_q[1] <= TrigIn;
          state_q  <= ST_T0;
        end
        ST_T0: begin
          tag_q[0] <= TrigIn;
          state_q  <= ST_PR;
        end
        ST_PR: begin
          state_q <= ST_IDLE;
          if (accept) trig_tag_q <= tag_q;
          // Overflowed frames still resynchronise the expected sequence.
          if (accept || ovf) exp_tag_q <= tag_q + 1'b1;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  pct_tag_fifo #(.NBUF(NBUF)) u_fifo (
    .clk_i   (Clock),
    .rst_ni  (Reset),
    .push_i  (accept),
    .pop_i   (rel_pop),
    .din_i   (tag_q),
    .count_o (occ),
    .head_o  (head)
  );

  assign Trig      = trig_q;
  assign TrigTag   = trig_tag_q;
  assign BufClr    = buf_clr_q;
  assign Occ       = occ;
  assign HeadTag   = head;
  assign HeadValid = (occ != 3'd0);
  assign ParErr    = par_err_q;
  assign TagErr    = tag_err_q;
  assign OvfErr    = ovf_err_q;
  assign RelErr    = rel_err_q;

`ifdef PCT_TRIG_RX_STATS_EN
  logic [3:0] stat_evt;
  assign stat_evt = {tag_bad, ovf, par_bad, accept};

  for (genvar gi = 0; gi < 4; gi++) begin : g_stat
    logic [15:0] cnt_q;
    always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) cnt_q <= '0;
      else if (stat_evt[gi] && (cnt_q != 16'hFFFF)) cnt_q <= cnt_q + 16'd1;
    end
  end

  assign NTrig   = g_stat[0].cnt_q;
  assign NPar    = g_stat[1].cnt_q;
  assign NOvf    = g_stat[2].cnt_q;
  assign NTagErr = g_stat[3].cnt_q;
`endif

endmodule

// File: tb/tb_pct_trig_rx.sv
// Scoreboard bench for pct_trig_rx: expected pulse sets are queued per cycle
// when frames/releases are driven and matched by a negedge monitor.
module tb_pct_trig_rx;

  localparam int NBUF      = 4;
  localparam int BUF_GUARD = 1;

  logic       Clock = 1'b0;
  logic       Reset, TrigIn, BufRelease;
  logic [1:0] RelTag;
  logic       Trig, BufClr, HeadValid, ParErr, TagErr, OvfErr, RelErr;
  logic [1:0] TrigTag, HeadTag;
  logic [2:0] Occ;
`ifdef PCT_TRIG_RX_STATS_EN
  logic [15:0] NTrig, NPar, NOvf, NTagErr;
`endif

  pct_trig_rx #(.NBUF(NBUF), .BUF_GUARD(BUF_GUARD)) dut (
    .Clock      (Clock),
    .Reset      (Reset),
    .TrigIn     (TrigIn),
    .BufRelease (BufRelease),
    .RelTag     (RelTag),
    .Trig       (Trig),
    .TrigTag    (TrigTag),
    .BufClr     (BufClr),
    .Occ        (Occ),
    .HeadTag    (HeadTag),
    .HeadValid  (HeadValid),
    .ParErr     (ParErr),
    .TagErr     (TagErr),
    .OvfErr     (OvfErr),
    .RelErr     (RelErr)
`ifdef PCT_TRIG_RX_STATS_EN
    ,
    .NTrig      (NTrig),
    .NPar       (NPar),
    .NOvf       (NOvf),
    .NTagErr    (NTagErr)
`endif
  );

  always #5 Clock = ~Clock;

  // pulse bits: {RelErr, OvfErr, TagErr, ParErr, Trig}
  typedef struct {
    int         cyc;
    logic [4:0] pulses;
    logic [1:0] tag;
  } exp_t;

  exp_t       sb[$];
  logic [1:0] mq[$];
  logic [1:0] exp_tag_m;
  int         tests = 0;
  int         fails = 0;
  int         cyc = 0;
  bit         mon_en = 1'b0;
  logic [4:0] mon_obs;
  exp_t       mon_e;

  always @(posedge Clock) cyc++;

  always @(negedge Clock) begin
    if (mon_en) begin
      mon_obs = {RelErr, OvfErr, TagErr, ParErr, Trig};
      while (sb.size() > 0 && sb[0].cyc < cyc) begin
        mon_e = sb.pop_front();
        tests++; fails++;
        $display("FAIL missed_event cyc=%0d got none, required pulses=%b", mon_e.cyc, mon_e.pulses);
      end
      if (sb.size() > 0 && sb[0].cyc == cyc) begin
        mon_e = sb.pop_front();
        tests++;
        if (mon_obs !== mon_e.pulses) begin
          fails++;
          $display("FAIL pulses cyc=%0d got %b required %b", cyc, mon_obs, mon_e.pulses);
        end else begin
          $display("[TB] cyc=%0d pulses=%b trigtag=%0d occ=%0d", cyc, mon_obs, TrigTag, Occ);
        end
        if (mon_e.pulses[0]) begin
          tests++;
          if (TrigTag !== mon_e.tag) begin
            fails++;
            $display("FAIL trig_tag cyc=%0d got %0d required %0d", cyc, TrigTag, mon_e.tag);
          end
        end
      end else begin
        tests++;
        if (mon_obs !== 5'b0) begin
          fails++;
          $display("FAIL spurious_pulse cyc=%0d got %b required 00000", cyc, mon_obs);
        end
      end
    end
  end

  function automatic void add_exp(int c, logic [4:0] p, logic [1:0] t);
    exp_t e;
    if (p == 5'b0) return;
    for (int i = 0; i < sb.size(); i++) begin
      if (sb[i].cyc == c) begin
        e = sb[i];
        e.pulses = e.pulses | p;
        if (p[0]) e.tag = t;
        sb[i] = e;
        return;
      end
    end
    e.cyc = c; e.pulses = p; e.tag = t;
    sb.push_back(e);
  endfunction

  function automatic void model_release(logic [1:0] rt, int c);
    logic err;
    if (mq.size() == 0) err = 1'b1;
    else begin
      err = (rt != mq[0]);
      void'(mq.pop_front());
    end
    if (err) add_exp(c, 5'b10000, 2'd0);
  endfunction

  function automatic void model_frame(logic [1:0] tag, bit bad, int c, int occ_pre);
    logic [4:0] p;
    if (bad) add_exp(c, 5'b00010, 2'd0);
    else if (occ_pre == NBUF) begin
      add_exp(c, 5'b01000, 2'd0);
      exp_tag_m = 2'(tag + 2'd1);
    end else begin
      p = 5'b00001;
      if (tag != exp_tag_m) p = p | 5'b00100;
      add_exp(c, p, tag);
      mq.push_back(tag);
      exp_tag_m = 2'(tag + 2'd1);
    end
  endfunction

  // Called on a negedge; returns on the negedge after the decision edge.
  task automatic send_frame(input logic [1:0] tag, input bit bad, input bit rel, input logic [1:0] rt);
    int   c0;
    int   occ_pre;
    logic par;
    c0 = cyc;
    occ_pre = mq.size();
    par = ~(tag[1] ^ tag[0]);
    if (bad) par = ~par;
    if (rel) model_release(rt, c0 + 4);
    model_frame(tag, bad, c0 + 4, occ_pre);
    TrigIn = 1'b1;
    @(negedge Clock) TrigIn = tag[1];
    @(negedge Clock) TrigIn = tag[0];
    @(negedge Clock) begin
      TrigIn = par;
      if (rel) begin BufRelease = 1'b1; RelTag = rt; end
    end
    @(negedge Clock) begin
      TrigIn = 1'b0;
      BufRelease = 1'b0;
    end
  endtask

  task automatic do_release(input logic [1:0] rt);
    model_release(rt, cyc + 1);
    BufRelease = 1'b1;
    RelTag = rt;
    @(negedge Clock) BufRelease = 1'b0;
  endtask

  task automatic do_reset();
    mon_en = 1'b0;
    Reset = 1'b0; TrigIn = 1'b0; BufRelease = 1'b0; RelTag = 2'd0;
    sb.delete(); mq.delete(); exp_tag_m = 2'd0;
    repeat (2) @(negedge Clock);
    Reset = 1'b1;
    mon_en = 1'b1;
  endtask

  task automatic test_reset();
    mon_en = 1'b0;
    Reset = 1'b0; TrigIn = 1'b0; BufRelease = 1'b0; RelTag = 2'd0;
    sb.delete(); mq.delete(); exp_tag_m = 2'd0;
    repeat (2) @(negedge Clock);
    tests++; if ({Trig, ParErr, TagErr, OvfErr, RelErr} !== 5'b0) begin fails++; $display("FAIL reset_pulses got %b required 00000", {Trig, ParErr, TagErr, OvfErr, RelErr}); end
    tests++; if (BufClr !== 1'b1) begin fails++; $display("FAIL reset_bufclr got %b required 1", BufClr); end
    tests++; if (Occ !== 3'd0) begin fails++; $display("FAIL reset_occ got %0d required 0", Occ); end
    tests++; if ({TrigTag, HeadTag, HeadValid} !== 5'b0) begin fails++; $display("FAIL reset_tags got %b required 00000", {TrigTag, HeadTag, HeadValid}); end
    Reset = 1'b1;
    mon_en = 1'b1;
    @(negedge Clock);
  endtask

  task automatic test_basic();
    do_reset();
    send_frame(2'd0, 1'b0, 1'b0, 2'd0);
    tests++; if (Occ !== 3'd1 || BufClr !== 1'b1) begin fails++; $display("FAIL basic_occ1 got occ=%0d clr=%b required occ=1 clr=1", Occ, BufClr); end
    send_frame(2'd1, 1'b0, 1'b0, 2'd0);
    send_frame(2'd2, 1'b0, 1'b0, 2'd0);
    tests++; if (Occ !== 3'd3) begin fails++; $display("FAIL basic_occ3 got %0d required 3", Occ); end
    tests++; if (BufClr !== 1'b0) begin fails++; $display("FAIL basic_bufclr got %b required 0", BufClr); end
    tests++; if (HeadTag !== 2'd0 || HeadValid !== 1'b1) begin fails++; $display("FAIL basic_head got %0d/%b required 0/1", HeadTag, HeadValid); end
    @(negedge Clock);
    tests++; if (TrigTag !== 2'd2) begin fails++; $display("FAIL basic_tag_hold got %0d required 2", TrigTag); end
  endtask

  task automatic test_parity();
    do_reset();
    send_frame(2'd0, 1'b0, 1'b0, 2'd0);
    send_frame(2'd1, 1'b0, 1'b0, 2'd0);
    send_frame(2'd2, 1'b1, 1'b0, 2'd0);
    tests++; if (Occ !== 3'd2 || BufClr !== 1'b1) begin fails++; $display("FAIL parity_occ got occ=%0d clr=%b required occ=2 clr=1", Occ, BufClr); end
    send_frame(2'd2, 1'b0, 1'b0, 2'd0);
    tests++; if (Occ !== 3'd3) begin fails++; $display("FAIL parity_occ_after got %0d required 3", Occ); end
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 0; i < 4; i++) send_frame(2'(i), 1'b0, 1'b0, 2'd0);
    tests++; if (Occ !== 3'd4) begin fails++; $display("FAIL ovf_fill got %0d required 4", Occ); end
    send_frame(2'd0, 1'b0, 1'b0, 2'd0);
    tests++; if (Occ !== 3'd4 || HeadTag !== 2'd0 || BufClr !== 1'b0) begin fails++; $display("FAIL ovf_state got occ=%0d head=%0d clr=%b required 4/0/0", Occ, HeadTag, BufClr); end
  endtask

  task automatic test_coincident();
    do_reset();
    send_frame(2'd0, 1'b0, 1'b0, 2'd0);
    send_frame(2'd1, 1'b0, 1'b0, 2'd0);
    send_frame(2'd2, 1'b0, 1'b1, 2'd0);
    tests++; if (Occ !== 3'd2) begin fails++; $display("FAIL coinc_occ got %0d required 2", Occ); end
    tests++; if (HeadTag !== 2'd1) begin fails++; $display("FAIL coinc_head got %0d required 1", HeadTag); end
  endtask

  task automatic test_tag_err();
    do_reset();
    send_frame(2'd0, 1'b0, 1'b0, 2'd0);
    send_frame(2'd3, 1'b0, 1'b0, 2'd0);
    send_frame(2'd0, 1'b0, 1'b0, 2'd0);
    tests++; if (Occ !== 3'd3) begin fails++; $display("FAIL tagerr_occ got %0d required 3", Occ); end
  endtask

  task automatic test_release();
    // queue holds 0,3,0 from the previous scenario
    do_release(2'd0);
    do_release(2'd0);
    tests++; if (Occ !== 3'd1 || HeadTag !== 2'd0) begin fails++; $display("FAIL rel_pop got occ=%0d head=%0d required 1/0", Occ, HeadTag); end
    do_release(2'd0);
    tests++; if (Occ !== 3'd0 || HeadValid !== 1'b0 || BufClr !== 1'b1) begin fails++; $display("FAIL rel_empty got occ=%0d hv=%b clr=%b required 0/0/1", Occ, HeadValid, BufClr); end
    do_release(2'd1);
    @(negedge Clock);
    tests++; if (Occ !== 3'd0) begin fails++; $display("FAIL rel_underflow got %0d required 0", Occ); end
  endtask

  task automatic test_back_to_back();
    logic [1:0] t, rt, mh;
    bit         bad, rel;
    do_reset();
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        rt = (mq.size() > 0 && $urandom_range(0, 1) == 1) ? mq[0] : 2'($urandom_range(0, 3));
        do_release(rt);
      end else begin
        t   = ($urandom_range(0, 9) < 7) ? exp_tag_m : 2'($urandom_range(0, 3));
        bad = ($urandom_range(0, 7) == 0);
        rel = ($urandom_range(0, 3) == 0);
        rt  = (mq.size() > 0 && $urandom_range(0, 3) != 0) ? mq[0] : 2'($urandom_range(0, 3));
        send_frame(t, bad, rel, rt);
      end
      mh = (mq.size() > 0) ? mq[0] : 2'd0;
      tests++;
      if (Occ !== 3'(mq.size()) || HeadTag !== mh || BufClr !== ((mq.size() + BUF_GUARD) < NBUF)) begin
        fails++;
        $display("FAIL b2b_state it=%0d got occ=%0d head=%0d clr=%b required occ=%0d head=%0d clr=%b",
                 i, Occ, HeadTag, BufClr, mq.size(), mh, ((mq.size() + BUF_GUARD) < NBUF));
      end
    end
  endtask

  task automatic test_reset_midframe();
    do_reset();
    TrigIn = 1'b1;
    @(negedge Clock) TrigIn = 1'b1;
    @(negedge Clock) begin
      mon_en = 1'b0;
      Reset = 1'b0;
      TrigIn = 1'b0;
    end
    sb.delete(); mq.delete(); exp_tag_m = 2'd0;
    @(negedge Clock) begin
      Reset = 1'b1;
      mon_en = 1'b1;
    end
    send_frame(2'd0, 1'b0, 1'b0, 2'd0);
    tests++; if (Occ !== 3'd1 || HeadTag !== 2'd0) begin fails++; $display("FAIL midreset_occ got occ=%0d head=%0d required 1/0", Occ, HeadTag); end
    repeat (6) @(negedge Clock);
  endtask

  initial begin
    Reset = 1'b0; TrigIn = 1'b0; BufRelease = 1'b0; RelTag = 2'd0; exp_tag_m = 2'd0;
    @(negedge Clock);
    test_reset();
    test_basic();
    test_parity();
    test_overflow();
    test_coincident();
    test_tag_err();
    test_release();
    test_back_to_back();
    test_reset_midframe();
    repeat (3) @(negedge Clock);
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL sb_drain got %0d pending required 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
